// File: rtl/rr_ring_arbiter_pkg.sv
// Shared types and default sizing for the round-robin ring arbiter.
package rr_ring_arbiter_pkg;

    localparam int RR_N_DEFAULT        = 3;
    localparam int RR_MAX_HOLD_DEFAULT = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } rr_state_t;

endpackage

// File: rtl/rr_ring_arbiter_ptr.sv
// One-hot ring pointer: resets to bit0, loads onehot(owner+1) with wrap.
module rr_ring_ptr
    import rr_ring_arbiter_pkg::*;
#(
    parameter int N  = RR_N_DEFAULT,
    parameter int OW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [OW-1:0] owner,
    output logic [N-1:0]  ptr
);

    logic [N-1:0] r_ptr;
    logic [N-1:0] w_ptr_nxt;

    always_comb begin
        w_ptr_nxt = '0;
        for (int i = 0; i < N; i++) begin
            w_ptr_nxt[i] = (i == ((int'(owner) + 1) % N));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= N'(1);
        end else if (load) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with registered one-hot grant, done/req-drop release
// and a MAX_HOLD timeout; priority rotates one past the last owner.
module rr_ring_arbiter
    import rr_ring_arbiter_pkg::*;
#(
    parameter int N        = RR_N_DEFAULT,
    parameter int MAX_HOLD = RR_MAX_HOLD_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic [N-1:0] done,
    output logic [N-1:0] grant,
    output logic         busy,
    output logic [N-1:0] ptr,
    output logic         timeout
);

    localparam int OW = (N > 1) ? $clog2(N) : 1;
    localparam int HW = $clog2(MAX_HOLD);

    rr_state_t     r_state;
    rr_state_t     w_state_nxt;
    logic [N-1:0]  r_grant;
    logic [N-1:0]  w_grant_nxt;
    logic [OW-1:0] r_owner;
    logic [OW-1:0] w_owner_nxt;
    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_nxt;
    logic          r_timeout;
    logic          w_timeout_nxt;
    logic          w_release;

    logic [N-1:0]  w_ptr;
    logic [OW-1:0] w_ptr_idx;
    logic [N-1:0]  w_rot;
    logic          w_found;
    logic [OW-1:0] w_win;
    logic          w_own_done;
    logic          w_own_req;
    logic          w_hold_lim;

    rr_ring_ptr #(
        .N  (N),
        .OW (OW)
    ) u_ptr (
        .clk   (clk),
        .reset (reset),
        .load  (w_release),
        .owner (r_owner),
        .ptr   (w_ptr)
    );

    always_comb begin
        w_ptr_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (w_ptr[i]) begin
                w_ptr_idx = OW'(i);
            end
        end
    end

    // Rotate req so bit 0 is the highest-priority requester, then take the first set bit.
    assign w_rot = N'({req, req} >> w_ptr_idx);

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_win   = OW'((int'(w_ptr_idx) + i) % N);
            end
        end
    end

    assign w_own_done = |(done & r_grant);
    assign w_own_req  = |(req & r_grant);
    assign w_hold_lim = (r_hold == HW'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_owner   <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_owner   <= w_owner_nxt;
            r_hold    <= w_hold_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_owner_nxt   = r_owner;
        w_hold_nxt    = r_hold;
        w_timeout_nxt = 1'b0;
        w_release     = 1'b0;
        case (r_state)
            GRANT: begin
                if (w_own_done || !w_own_req || w_hold_lim) begin
                    w_release     = 1'b1;
                    w_state_nxt   = IDLE;
                    w_grant_nxt   = '0;
                    w_hold_nxt    = '0;
                    w_timeout_nxt = w_hold_lim && !w_own_done && w_own_req;
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            default: begin
                w_grant_nxt = '0;
                if (w_found) begin
                    w_state_nxt = GRANT;
                    w_owner_nxt = w_win;
                    w_hold_nxt  = '0;
                    for (int i = 0; i < N; i++) begin
                        w_grant_nxt[i] = (OW'(i) == w_win);
                    end
                end
            end
        endcase
    end

    always_comb begin
        grant   = r_grant;
        busy    = |r_grant;
        ptr     = w_ptr;
        timeout = r_timeout;
    end

endmodule
